console_uart_rx: RTL and testbench

//  Serial console receiver: the input end of the text console whose output side prints messages.

---
 rtl/console_uart_pkg.sv | 27 ++
 rtl/console_sync2.sv | 29 ++
 rtl/console_uart_rx.sv | 144 ++++++++++++++
 tb/tb_console_uart_rx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/console_uart_pkg.sv
// Shared definitions for the serial console: FSM states, frame constants
// and a width helper used by both the receiver and the transmitter.
package console_uart_pkg;

    // Receiver FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_e;

    // 8N1 frame line levels.
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Number of bits needed to count 0..v-1 (minimum 1).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/console_sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
module console_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops to settle metastability.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/console_uart_rx.sv
// Console serial receiver: deserialises an 8N1-style line into bytes and
// hands them over through a one-deep valid/ready holding register.
module console_uart_rx
    import console_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int CNT_W = clog2(CLKS_PER_BIT);
    localparam int IDX_W = clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rxs;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 deliver;

    console_sync2 #(.RESET_VAL(LINE_IDLE)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx_i),
        .q_o   (rxs)
    );

    // Frame FSM next state, bit timing and the holding-register update.
    // NOTE: every signal gets its default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (rxs == START_BIT) begin
                    state_d = ST_START;
                    cnt_d   = CNT_HALF;
                end
            end
            ST_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs == START_BIT) begin
                    state_d = ST_DATA;
                    cnt_d   = CNT_FULL;
                    idx_d   = '0;
                end else begin
                    state_d = ST_IDLE;      // glitch shorter than half a bit
                end
            end
            ST_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = CNT_FULL;
                    if (idx_q == IDX_LAST) state_d = ST_STOP;
                    else                   idx_d   = idx_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs == STOP_BIT) begin
                    deliver = 1'b1;
                    state_d = ST_IDLE;      // re-arm at mid stop bit
                end else begin
                    ferr_d  = 1'b1;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (rxs == LINE_IDLE) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (deliver) begin
            if (!valid_q || ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;               // old byte kept, new one dropped
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    // State, timing, shift and holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_console_uart_rx.sv
// Bench for console_uart_rx: a bit-time line model drives rx_i, expected
// bytes go into a scoreboard queue, and a monitor pops and compares on
// every accepted byte while counting error pulses.
module tb_console_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int total = 0;
    int bad   = 0;
    int acc_cnt  = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    logic [7:0] exp_q[$];

    console_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Advance n clock edges, ending just after the last rising edge.
    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_i = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            wait_clks(CPB);
        end
        rx_i = stop;
        wait_clks(CPB);
        rx_i = 1'b1;
    endtask

    // Monitor: pop the scoreboard on each accepted byte, count pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_o && ready_i) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 32'(data_o), 32'hFFFF_FFFF);
                end else begin
                    check("data_o", 32'(data_o), 32'(exp_q.pop_front()));
                end
            end
            if (frame_err_o) ferr_cnt++;
            if (overrun_o)   ovr_cnt++;
            if (frame_err_o || overrun_o)
                check("ferr_and_ovr_exclusive", 32'(frame_err_o & overrun_o), 32'd0);
        end
    end

    initial begin
        int a0, f0, o0;
        bit idle_seen;
        logic [7:0] hello [5];
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

        rst_n   = 1'b0;
        rx_i    = 1'b1;
        ready_i = 1'b1;
        wait_clks(3);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_data",  32'(data_o), 32'd0);
        check("rst_ferr",  32'(frame_err_o), 32'd0);
        check("rst_ovr",   32'(overrun_o), 32'd0);
        rst_n = 1'b1;
        wait_clks(4);

        // 1. single byte with consumer ready
        a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'h48);
        send_frame(8'h48, 1'b1);
        wait_clks(4);
        check("t1_accepts", 32'(acc_cnt - a0), 32'd1);
        check("t1_ferr",    32'(ferr_cnt - f0), 32'd0);
        check("t1_ovr",     32'(ovr_cnt - o0), 32'd0);

        // 2. short glitch on an idle line
        a0 = acc_cnt; f0 = ferr_cnt;
        rx_i = 1'b0;
        wait_clks(3);
        rx_i = 1'b1;
        idle_seen = 1'b0;
        for (int i = 0; i < 12 && !idle_seen; i++) begin
            wait_clks(1);
            if (!busy_o) idle_seen = 1'b1;
        end
        check("t2_busy_cleared", 32'(idle_seen), 32'd1);
        wait_clks(CPB);
        check("t2_accepts", 32'(acc_cnt - a0), 32'd0);
        check("t2_ferr",    32'(ferr_cnt - f0), 32'd0);

        // 3. framing error then a good byte
        a0 = acc_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b0);
        wait_clks(CPB);
        check("t3_ferr_once", 32'(ferr_cnt - f0), 32'd1);
        check("t3_no_byte",   32'(acc_cnt - a0), 32'd0);
        exp_q.push_back(8'h21);
        send_frame(8'h21, 1'b1);
        wait_clks(4);
        check("t3_accepts", 32'(acc_cnt - a0), 32'd1);
        check("t3_ferr_total", 32'(ferr_cnt - f0), 32'd1);

        // 4. overrun with consumer stalled
        a0 = acc_cnt; o0 = ovr_cnt;
        ready_i = 1'b0;
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1);
        send_frame(8'h42, 1'b1);
        wait_clks(4);
        check("t4_ovr_once", 32'(ovr_cnt - o0), 32'd1);
        check("t4_valid_held", 32'(valid_o), 32'd1);
        check("t4_data_held", 32'(data_o), 32'h41);
        check("t4_no_accept", 32'(acc_cnt - a0), 32'd0);
        ready_i = 1'b1;
        wait_clks(1);
        ready_i = 1'b0;
        check("t4_valid_fell", 32'(valid_o), 32'd0);
        check("t4_accept_one", 32'(acc_cnt - a0), 32'd1);
        ready_i = 1'b1;
        wait_clks(2);

        // 5. reset during data bit 4 of 0xFF
        a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        rx_i = 1'b0;
        wait_clks(CPB);
        rx_i = 1'b1;
        wait_clks(4 * CPB + CPB / 2);
        check("t5_busy_before_rst", 32'(busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_busy_async", 32'(busy_o), 32'd0);
        check("t5_valid_async", 32'(valid_o), 32'd0);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(4);
        exp_q.push_back(8'h0A);
        send_frame(8'h0A, 1'b1);
        wait_clks(4);
        check("t5_accepts", 32'(acc_cnt - a0), 32'd1);
        check("t5_ferr",    32'(ferr_cnt - f0), 32'd0);
        check("t5_ovr",     32'(ovr_cnt - o0), 32'd0);

        // 6. back-to-back "Hello"
        a0 = acc_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
        for (int i = 0; i < 5; i++) exp_q.push_back(hello[i]);
        for (int i = 0; i < 5; i++) send_frame(hello[i], 1'b1);
        wait_clks(4);
        check("t6_accepts", 32'(acc_cnt - a0), 32'd5);
        check("t6_ferr",    32'(ferr_cnt - f0), 32'd0);
        check("t6_ovr",     32'(ovr_cnt - o0), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
